// File: rtl/cpu_pkg.sv
// Shared constants and the fetch-stage state encoding for the 16-bit datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int              CPU_WIDTH     = 16;
    localparam logic [15:0]     CPU_RESET_VEC = 16'h0000;
    localparam logic [15:0]     CPU_INC       = 16'd2;

    // Encoded as {fetch_valid, redirect_pending} so the outputs fall straight out of the state.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REQ      = 2'b10,
        ST_REQ_PEND = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/mux16b2.sv
// 2:1 word mux used for next-PC selection: y = s ? b : a.
// Latency: purely combinational.
// Backpressure: none.
module mux16b2 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter: issues fetch addresses over valid/ready, takes branch redirects.
// Latency: registered pc; redirect coinciding with accept costs zero bubbles.
// Backpressure: address/valid held until accepted; late branches parked in redirect_pending.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH     = CPU_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(CPU_RESET_VEC),
    parameter logic [WIDTH-1:0] INC       = WIDTH'(CPU_INC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_take,
    input  logic [WIDTH-1:0] br_target,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             redirect_pending
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

    logic             accept;
    logic             redir;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] next_pc;

    // A fresh branch always beats one that is already parked.
    assign pc_plus = pc_q + INC;
    assign accept  = fetch_valid & fetch_ready;
    assign redir   = br_take | redirect_pending;
    assign tgt     = br_take ? br_target : pend_tgt_q;

    mux16b2 #(
        .WIDTH (WIDTH)
    ) u_next_pc_mux (
        .a (pc_plus),
        .b (tgt),
        .s (redir),
        .y (next_pc)
    );

    // State and datapath registers; reset wins over any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VEC;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // Next state: hold address while unaccepted, advance or redirect on accept.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            ST_IDLE: begin
                // No sequential advance from idle; only a redirect moves the pc.
                if (redir) begin
                    pc_d = next_pc;
                end
                state_d = stall ? ST_IDLE : ST_REQ;
            end
            ST_REQ, ST_REQ_PEND: begin
                if (accept) begin
                    pc_d    = next_pc;
                    state_d = stall ? ST_IDLE : ST_REQ;
                end else if (br_take) begin
                    // Stall is ignored here: the live request must not be withdrawn.
                    state_d    = ST_REQ_PEND;
                    pend_tgt_d = br_target;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from the state encoding.
    always_comb begin
        fetch_valid      = (state_q == ST_REQ) || (state_q == ST_REQ_PEND);
        redirect_pending = (state_q == ST_REQ_PEND);
        pc               = pc_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_take = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic        fetch_ready = 1'b1;
    logic        fetch_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic        redirect_pending;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        v;
        logic        p;
        logic [15:0] a;
    } exp_t;

    exp_t sb_q[$];

    // Reference: the issued-address stream as plain variables.
    logic        m_v   = 1'b0;
    logic        m_p   = 1'b0;
    logic [15:0] m_pc  = 16'h0000;
    logic [15:0] m_tgt = 16'h0000;

    pc_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .br_take          (br_take),
        .br_target        (br_target),
        .fetch_ready      (fetch_ready),
        .fetch_valid      (fetch_valid),
        .pc               (pc),
        .pc_plus          (pc_plus),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    // Model: advance the expected request after each edge and queue it.
    always @(posedge clk) begin
        exp_t e;
        logic        have_redir;
        logic [15:0] where;
        have_redir = br_take | m_p;
        where      = br_take ? br_target : m_tgt;
        if (rst) begin
            m_v = 1'b0; m_p = 1'b0; m_pc = 16'h0000; m_tgt = 16'h0000;
        end else if (!m_v) begin
            if (have_redir) m_pc = where;
            m_p = 1'b0;
            m_v = !stall;
        end else if (fetch_ready) begin
            m_pc = have_redir ? where : 16'((32'(m_pc) + 2) % 65536);
            m_p  = 1'b0;
            m_v  = !stall;
        end else if (br_take) begin
            m_p   = 1'b1;
            m_tgt = br_target;
        end
        e.v = m_v; e.p = m_p; e.a = m_pc;
        sb_q.push_back(e);
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
    endtask

    // Monitor: compare the DUT's presented state against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("fetch_valid", {15'd0, fetch_valid}, {15'd0, e.v});
            chk("redirect_pending", {15'd0, redirect_pending}, {15'd0, e.p});
            chk("pc", pc, e.a);
            chk("pc_plus", pc_plus, 16'((32'(e.a) + 2) % 65536));
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // Run with ready=1 until the model presents the given address.
    task automatic wait_pc(input logic [15:0] addr);
        int budget;
        budget = 200;
        while (!(m_v && m_pc == addr) && budget > 0) begin
            step(1);
            budget--;
        end
        if (budget == 0) begin
            n_total++;
            $display("FAIL wait_pc: address %h never presented within budget", addr);
        end
    endtask

    initial begin
        // Reset then free run.
        stall = 0; fetch_ready = 1; br_take = 0;
        do_reset();
        step(5);

        // Back-pressure at 0x0010.
        wait_pc(16'h0010);
        fetch_ready = 0; step(3);
        fetch_ready = 1; step(2);

        // Branch coinciding with accept.
        do_reset();
        wait_pc(16'h0004);
        br_take = 1; br_target = 16'h0100; step(1);
        br_take = 0; step(3);

        // Two branches while waiting: latest wins.
        fetch_ready = 0;
        br_take = 1; br_target = 16'h0200; step(1);
        br_target = 16'h0300; step(1);
        br_take = 0; step(1);
        fetch_ready = 1; step(3);

        // Wrap past 0xFFFE.
        br_take = 1; br_target = 16'hFFFC; step(1);
        br_take = 0; step(4);

        // Stall from idle, then stall under an unaccepted request.
        rst = 1; stall = 1; step(2);
        rst = 0; step(3);
        stall = 0; step(3);
        fetch_ready = 0; stall = 1; step(2);
        fetch_ready = 1; step(3);
        stall = 0; step(2);

        // Branch and stall together on an accept cycle.
        stall = 1; br_take = 1; br_target = 16'h0800; step(1);
        br_take = 0; step(2);
        stall = 0; step(3);

        // Reset while a redirect is parked.
        fetch_ready = 0;
        br_take = 1; br_target = 16'h0400; step(1);
        br_take = 0; step(1);
        rst = 1; step(1);
        rst = 0; fetch_ready = 1; step(3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom % 4) == 0;
            fetch_ready = ($urandom % 3) != 0;
            br_take     = ($urandom % 6) == 0;
            br_target   = (($urandom % 8) == 0) ? 16'hFFFE : 16'($urandom);
            rst         = ($urandom % 250) == 0;
            step(1);
        end
        rst = 0; stall = 0; br_take = 0; fetch_ready = 1;
        step(2);
        @(negedge clk);
        #1;
        n_total++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
